dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data-memory port between two requesters: the pipeline MEM stage (CPU) and a debug/loader master (DBG).
- CPU has fixed priority.
- A starvation counter guarantees DBG a bounded wait. When it expires, the arbiter takes the port for a short burst and stalls the pipeline.
- Sits between the EX/MEM register outputs and datamemory. cpu_stall ORs into the pipeline's existing freeze path (PC hold, IF/ID hold, ID/EX bubble).

Parameters:
ADDR_W  9  data-memory byte address width
DATA_W  32  data width
MAX_WAIT  8  consecutive denied DBG cycles before forced DBG ownership (>=1)
BURST  4  max DBG grants per forced-ownership window (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
cpu_rd  input  1  MEM-stage read enable
cpu_wr  input  1  MEM-stage write enable
cpu_addr  input  ADDR_W  MEM-stage address
cpu_wdata  input  DATA_W  MEM-stage store data
cpu_funct3  input  3  load/store size code, forwarded to memory
cpu_rdata  output  DATA_W  load data to MEM/WB register
cpu_stall  output  1  freeze pipeline this cycle
dbg_req  input  1  DBG request, held until granted
dbg_we  input  1  1 = word write, 0 = word read
dbg_addr  input  ADDR_W  DBG address
dbg_wdata  input  DATA_W  DBG write data
dbg_gnt  output  1  DBG access performed this cycle
dbg_rvalid  output  1  DBG read data valid (1-cycle pulse)
dbg_rdata  output  DATA_W  DBG read data, registered
mem_rd  output  1  memory read enable
mem_wr  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_funct3  output  3  memory size code
mem_rdata  input  DATA_W  memory read data, combinational from mem_addr

Behaviour:
- Definitions: cpu_acc = cpu_rd | cpu_wr. States: S_CPU, S_DBG. Counters: wait_cnt (0..MAX_WAIT-1), beat_cnt (0..BURST-1).
- Reset values: state S_CPU, wait_cnt 0, beat_cnt 0, dbg_rvalid 0, dbg_rdata 0.
- Grant logic (combinational, same cycle):
  - dbg_gnt = dbg_req & (!cpu_acc | state==S_DBG).
  - cpu_stall = cpu_acc & dbg_req & state==S_DBG.
- Port mux:
  - When dbg_gnt: mem_rd=!dbg_we, mem_wr=dbg_we, mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_funct3=3'b010.
  - Otherwise: CPU signals pass straight through. Idle cycles pass CPU signals with rd/wr=0.
  - cpu_rdata = mem_rdata always; meaningful only when the CPU owns the port.
- CPU latency: 0 added cycles, so the existing MEM-stage timing is unchanged.
- DBG read: dbg_rdata <= mem_rdata on a cycle with dbg_gnt & !dbg_we. dbg_rvalid is 1 the following cycle only. DBG write completes in the grant cycle.
- wait_cnt:
  - Increments on each cycle with dbg_req & !dbg_gnt.
  - Clears on dbg_gnt or !dbg_req.
- S_CPU -> S_DBG: when dbg_req & !dbg_gnt & wait_cnt==MAX_WAIT-1. Clears wait_cnt and beat_cnt.
- In S_DBG:
  - beat_cnt increments per grant.
  - Return to S_CPU when !dbg_req, or on the grant with beat_cnt==BURST-1. Clear beat_cnt.
- While in S_DBG: cpu_stall stays high only while cpu_acc & dbg_req. The stalled CPU request must stay unchanged; the pipeline freeze guarantees this.
- Simultaneous events:
  - CPU idle + dbg_req: DBG granted in any state; no stall.
  - In S_CPU, CPU always wins.
  - dbg_req drop in the same cycle as the expiry condition: no transition.
- Reset mid-burst: state returns to S_CPU; any pending dbg_rvalid is suppressed (held 0 the next cycle).
- DBG protocol rule: dbg_we, dbg_addr and dbg_wdata must stay stable from dbg_req rise until dbg_gnt.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: adds perf_stall_cnt [15:0] and perf_dbg_cnt [15:0] output ports.
  - perf_stall_cnt counts cycles with cpu_stall=1.
  - perf_dbg_cnt counts dbg_gnt pulses.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists. Arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t enum {S_CPU, S_DBG}.
  - FUNCT3_WORD = 3'b010.
- One sub-module, arb_sat_counter (parameterised width and limit, increment/clear, terminal flag). Used for wait_cnt and beat_cnt, and for the perf counters when enabled.

Test Plan:
1. CPU sw to 0x010 data 0xDEADBEEF, then lw 0x010 with dbg_req=0 -> mem_wr then mem_rd pass through; cpu_rdata=0xDEADBEEF; cpu_stall never 1.
2. CPU idle, DBG read 0x020 (preloaded 0x12345678) -> dbg_gnt same cycle; dbg_rvalid next cycle with dbg_rdata=0x12345678.
3. CPU lw every cycle, DBG read pending (MAX_WAIT=8, BURST=4):
   - dbg_gnt=0 for 8 cycles, then S_DBG.
   - 4 DBG grants with cpu_stall=1 each, then back to S_CPU; CPU lw then completes with correct data.
4. In S_DBG after 2 grants, dbg_req drops -> S_DBG->S_CPU next edge; cpu_stall=0 immediately.
5. reset asserted the cycle after a DBG read grant -> dbg_rvalid stays 0; state S_CPU; counters 0.
6. (PERF_EN) scenario 3 -> perf_stall_cnt=4, perf_dbg_cnt=4.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared arbiter state type, memory size code and counter width helper.
package dmem_arb_pkg;

    typedef enum logic {S_CPU, S_DBG} arb_state_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmem_arbiter_counter.sv
// arb_sat_counter: saturating up-counter with clear priority and a terminal-value flag.
module arb_sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;

    assign cnt_o  = cnt_q;
    assign term_o = cnt_q == LIM;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority data-memory port sharing with bounded DBG wait; DMEM_ARB_PERF_EN adds perf counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int BURST    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_dbg_cnt
`endif
);

    localparam int WW = cnt_w(MAX_WAIT);
    localparam int BW = cnt_w(BURST);

    arb_state_t        state_q, state_d;
    logic              cpu_acc, in_dbg, wait_term, beat_term, expire, leave;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [WW-1:0]     unused_wait_cnt;
    logic [BW-1:0]     unused_beat_cnt;

    always_comb begin
        cpu_acc    = cpu_rd | cpu_wr;
        in_dbg     = state_q == S_DBG;
        dbg_gnt    = dbg_req & (!cpu_acc | in_dbg);
        cpu_stall  = cpu_acc & dbg_req & in_dbg;
        mem_rd     = dbg_gnt ? !dbg_we : cpu_rd;
        mem_wr     = dbg_gnt ? dbg_we : cpu_wr;
        mem_addr   = dbg_gnt ? dbg_addr : cpu_addr;
        mem_wdata  = dbg_gnt ? dbg_wdata : cpu_wdata;
        mem_funct3 = dbg_gnt ? FUNCT3_WORD : cpu_funct3;
        cpu_rdata  = mem_rdata;
    end

    // A dropped request in the expiry cycle blocks the transition because dbg_req gates expire.
    always_comb begin
        expire   = !in_dbg & dbg_req & !dbg_gnt & wait_term;
        leave    = in_dbg & (!dbg_req | (dbg_gnt & beat_term));
        state_d  = expire ? S_DBG : leave ? S_CPU : state_q;
        rvalid_d = dbg_gnt & !dbg_we;
        rdata_d  = rvalid_d ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_CPU;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Reset squashes a read-valid that is already in flight.
    assign dbg_rvalid = rvalid_q & !reset;
    assign dbg_rdata  = rdata_q;

    arb_sat_counter #(.W(WW), .LIMIT(MAX_WAIT - 1)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (dbg_req & !dbg_gnt),
        .clr_i  (!dbg_req | dbg_gnt | expire),
        .cnt_o  (unused_wait_cnt),
        .term_o (wait_term)
    );

    arb_sat_counter #(.W(BW), .LIMIT(BURST - 1)) u_beat (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (in_dbg & dbg_gnt),
        .clr_i  (!in_dbg | leave),
        .cnt_o  (unused_beat_cnt),
        .term_o (beat_term)
    );

`ifdef DMEM_ARB_PERF_EN
    logic unused_stall_sat, unused_dbg_sat;

    arb_sat_counter #(.W(16), .LIMIT(65535)) u_perf_stall (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (cpu_stall),
        .clr_i  (1'b0),
        .cnt_o  (perf_stall_cnt),
        .term_o (unused_stall_sat)
    );

    arb_sat_counter #(.W(16), .LIMIT(65535)) u_perf_dbg (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (dbg_gnt),
        .clr_i  (1'b0),
        .cnt_o  (perf_dbg_cnt),
        .term_o (unused_dbg_sat)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int BURST    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr, cpu_stall, dbg_req, dbg_we, dbg_gnt, dbg_rvalid, mem_rd, mem_wr;
    logic [8:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [2:0]  cpu_funct3, mem_funct3;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_stall_cnt, perf_dbg_cnt;
    int          m_pstall, m_pdbg;
    logic [15:0] o_pstall, o_pdbg;
`endif

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_dbg_cnt(perf_dbg_cnt)
`endif
    );

    logic [31:0] mem [128];
    always @(posedge clk) if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[8:2]];

    logic [31:0] ref_mem [128];
    bit          m_dbg, m_rv;
    int          waited, beats, vectors, miscompares;
    logic [31:0] m_rd;
    logic        o_gnt, o_stall, o_rv;
    logic [31:0] o_cpu_rdata, o_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit crd, input bit cwr, input logic [8:0] ca,
                        input logic [31:0] cwd, input logic [2:0] cf, input bit dq, input bit dw,
                        input logic [8:0] da, input logic [31:0] dd);
        bit acc, eg, es;
        logic [31:0] rdv;
        reset = rst; cpu_rd = crd; cpu_wr = cwr; cpu_addr = ca; cpu_wdata = cwd; cpu_funct3 = cf;
        dbg_req = dq; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        #2;
        acc = crd | cwr;
        eg  = dq & (!acc | m_dbg);
        es  = acc & dq & m_dbg;
        o_gnt = dbg_gnt; o_stall = cpu_stall; o_rv = dbg_rvalid; o_rd = dbg_rdata; o_cpu_rdata = cpu_rdata;
        chk("dbg_gnt", 64'(dbg_gnt), 64'(eg));
        chk("cpu_stall", 64'(cpu_stall), 64'(es));
        chk("mem_rd", 64'(mem_rd), 64'(eg ? !dw : crd));
        chk("mem_wr", 64'(mem_wr), 64'(eg ? dw : cwr));
        chk("mem_addr", 64'(mem_addr), 64'(eg ? da : ca));
        chk("mem_wdata", 64'(mem_wdata), 64'(eg ? dd : cwd));
        chk("mem_funct3", 64'(mem_funct3), 64'(eg ? 3'b010 : cf));
        if (crd && !eg) chk("cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[ca[8:2]]));
        chk("dbg_rvalid", 64'(dbg_rvalid), 64'(rst ? 1'b0 : m_rv));
        chk("dbg_rdata", 64'(dbg_rdata), 64'(m_rd));
`ifdef DMEM_ARB_PERF_EN
        o_pstall = perf_stall_cnt; o_pdbg = perf_dbg_cnt;
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_pstall));
        chk("perf_dbg_cnt", 64'(perf_dbg_cnt), 64'(m_pdbg));
`endif
        @(posedge clk);
        rdv = ref_mem[da[8:2]];
        if (eg && dw) ref_mem[da[8:2]] = dd;
        else if (!eg && cwr) ref_mem[ca[8:2]] = cwd;
        if (rst) begin
            m_dbg = 0; m_rv = 0; m_rd = '0; waited = 0; beats = 0;
`ifdef DMEM_ARB_PERF_EN
            m_pstall = 0; m_pdbg = 0;
`endif
        end else begin
            m_rv = eg & !dw;
            if (m_rv) m_rd = rdv;
`ifdef DMEM_ARB_PERF_EN
            if (es && m_pstall < 65535) m_pstall++;
            if (eg && m_pdbg < 65535) m_pdbg++;
`endif
            if (m_dbg) begin
                if (dq) beats++;
                if (!dq || beats == BURST) begin m_dbg = 0; beats = 0; end
            end else if (dq && !eg) begin
                waited++;
                if (waited == MAX_WAIT) begin m_dbg = 1; waited = 0; beats = 0; end
            end else waited = 0;
        end
        #1;
    endtask

    initial begin
        int n;
        bit crd, cwr, dq, dw, rst;
        logic [8:0] ca, da;
        logic [31:0] cw, dd;
        logic [2:0] cf;
        vectors = 0; miscompares = 0;
        m_dbg = 0; m_rv = 0; m_rd = '0; waited = 0; beats = 0;
`ifdef DMEM_ARB_PERF_EN
        m_pstall = 0; m_pdbg = 0;
`endif
        reset = 1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b010;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        step(0, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        chk("reset_rvalid", 64'(o_rv), 64'd0);
        chk("reset_rdata", 64'(o_rd), 64'd0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 9'(i * 4), 32'hA5000000 | 32'(i), 3'b010, 0, 0, 9'h0, 0);

        // Scenario 1: CPU store then load, no DBG traffic
        step(0, 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0, 9'h0, 0);
        chk("t1_sw_stall", 64'(o_stall), 64'd0);
        step(0, 1, 0, 9'h010, 0, 3'b010, 0, 0, 9'h0, 0);
        chk("t1_lw_data", 64'(o_cpu_rdata), 64'hDEADBEEF);
        chk("t1_lw_stall", 64'(o_stall), 64'd0);
        step(0, 0, 1, 9'h020, 32'h12345678, 3'b010, 0, 0, 9'h0, 0);

        // Scenario 2: DBG read with idle CPU
        step(0, 0, 0, 9'h0, 0, 3'b010, 1, 0, 9'h020, 0);
        chk("t2_gnt", 64'(o_gnt), 64'd1);
        step(0, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        chk("t2_rvalid", 64'(o_rv), 64'd1);
        chk("t2_rdata", 64'(o_rd), 64'h12345678);

        // Scenario 3: starvation expiry and forced burst
        step(1, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        n = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            step(0, 1, 0, 9'h010, 0, 3'b010, 1, 0, 9'h020, 0);
            n += int'(o_gnt);
        end
        chk("t3_denied_grants", 64'(n), 64'd0);
        n = 0;
        for (int i = 0; i < BURST; i++) begin
            step(0, 1, 0, 9'h010, 0, 3'b010, 1, 0, 9'h020, 0);
            n += int'(o_gnt & o_stall);
        end
        chk("t3_burst_grants", 64'(n), 64'(BURST));
        step(0, 1, 0, 9'h010, 0, 3'b010, 1, 0, 9'h020, 0);
        chk("t3_back_gnt", 64'(o_gnt), 64'd0);
        chk("t3_back_stall", 64'(o_stall), 64'd0);
        chk("t3_lw_data", 64'(o_cpu_rdata), 64'hDEADBEEF);
`ifdef DMEM_ARB_PERF_EN
        chk("t6_perf_stall", 64'(o_pstall), 64'd4);
        chk("t6_perf_dbg", 64'(o_pdbg), 64'd4);
`endif

        // Scenario 4: request dropped mid-burst
        step(1, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        for (int i = 0; i < MAX_WAIT + 2; i++) step(0, 1, 0, 9'h010, 0, 3'b010, 1, 1, 9'h024, 32'h0BADF00D);
        step(0, 1, 0, 9'h010, 0, 3'b010, 0, 0, 9'h0, 0);
        chk("t4_drop_stall", 64'(o_stall), 64'd0);
        chk("t4_drop_gnt", 64'(o_gnt), 64'd0);
        step(0, 1, 0, 9'h010, 0, 3'b010, 1, 0, 9'h024, 0);
        chk("t4_cpu_state_gnt", 64'(o_gnt), 64'd0);
        chk("t4_cpu_state_stall", 64'(o_stall), 64'd0);

        // Scenario 5: reset right after a DBG read grant
        step(1, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        step(0, 0, 0, 9'h0, 0, 3'b010, 1, 0, 9'h020, 0);
        step(1, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        chk("t5_rvalid_in_reset", 64'(o_rv), 64'd0);
        step(0, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        chk("t5_rvalid_after", 64'(o_rv), 64'd0);
        n = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            step(0, 1, 0, 9'h010, 0, 3'b010, 1, 0, 9'h020, 0);
            n += int'(o_gnt);
        end
        chk("t5_wait_restart", 64'(n), 64'd0);
        step(0, 1, 0, 9'h010, 0, 3'b010, 1, 0, 9'h020, 0);
        chk("t5_forced_gnt", 64'(o_gnt), 64'd1);

        // Randomised traffic
        step(1, 0, 0, 9'h0, 0, 3'b010, 0, 0, 9'h0, 0);
        crd = 0; cwr = 0; ca = '0; cw = '0; cf = 3'b010;
        dq = 0; dw = 0; da = '0; dd = '0;
        for (int k = 0; k < 1500; k++) begin
            if (!o_stall) begin
                n   = int'($urandom_range(0, 9));
                crd = n < 5;
                cwr = n >= 5 && n < 8;
                ca  = 9'($urandom_range(0, 15) * 4);
                cw  = $urandom;
                cf  = 3'($urandom_range(0, 7));
            end
            if (!dq || o_gnt) begin
                dq = $urandom_range(0, 2) != 0;
                dw = 1'($urandom_range(0, 1));
                da = 9'($urandom_range(0, 15) * 4);
                dd = $urandom;
            end
            rst = $urandom_range(0, 199) == 0;
            step(rst, crd, cwr, ca, cw, cf, dq, dw, da, dd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
